// File: rtl/gpio_cmd_pkg.sv
// rtl/gpio_cmd_pkg.sv - shared command-word fields, codes and helpers for the GPIO config path
package gpio_cmd_pkg;

  localparam logic [3:0] CMD_IDX    = 4'h1;
  localparam logic [3:0] CMD_GAIN   = 4'h2;
  localparam logic [3:0] CMD_COMMIT = 4'hF;

  localparam int CMD_MSB  = 31;
  localparam int CMD_LSB  = 28;
  localparam int CH_BIT   = 27;
  localparam int TONE_MSB = 26;
  localparam int TONE_LSB = 24;
  localparam int DATA_MSB = 19;
  localparam int DATA_LSB = 0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } arb_state_t;

  function automatic logic is_commit(input logic [31:0] word);
    return word[CMD_MSB:CMD_LSB] == CMD_COMMIT;
  endfunction

endpackage

// File: rtl/gpio_cmd_arbiter_rr_pick.sv
// rtl/gpio_cmd_arbiter_rr_pick.sv - combinational round-robin search starting after last_owner
module rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      last_owner,
  output logic [IW-1:0]      pick,
  output logic               any_valid
);

  // Walk from the farthest candidate back to the nearest so the nearest valid one wins.
  always_comb begin
    int idx;
    pick      = last_owner;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (valid[idx[IW-1:0]]) begin
        pick      = idx[IW-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_cmd_arbiter.sv
// rtl/gpio_cmd_arbiter.sv - transaction-locked round-robin sharing of the gpio_wen/gpio_wdata bus
module gpio_cmd_arbiter
  import gpio_cmd_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int GAP_CYCLES     = 1,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    gpio_wen,
  output logic [31:0]             gpio_wdata,
  output logic                    locked,
  output logic [IW-1:0]           owner,
  output logic                    timeout_pulse,
  output logic                    busy
);

  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] last_owner_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] pick;
  logic [IW-1:0] sel;
  logic          any_valid;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] idle_cnt;
  logic [31:0]   sel_word;
  logic          xfer;
  logic          xfer_commit;
  logic          timeout_hit;
  logic          close_txn;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .valid      (req_valid),
    .last_owner (last_owner_q),
    .pick       (pick),
    .any_valid  (any_valid)
  );

  // While locked only the owner may talk; otherwise the round-robin winner.
  assign sel         = (state_q == S_IDLE) ? pick : owner_q;
  assign sel_word    = req_data[32*int'(sel) +: 32];
  assign xfer_commit = is_commit(sel_word);

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    xfer        = 1'b0;
    timeout_hit = 1'b0;
    close_txn   = 1'b0;
    if (gap_cnt == '0) begin
      if ((state_q == S_LOCK) || any_valid) begin
        req_ready[sel] = 1'b1;
      end
    end
    xfer = |(req_valid & req_ready);
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (xfer_commit) begin
            close_txn = 1'b1;
          end else begin
            state_d = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        // A transfer in the would-be timeout cycle takes precedence over the timeout.
        if (xfer) begin
          if (xfer_commit) begin
            close_txn = 1'b1;
            state_d   = S_IDLE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (idle_cnt == IDLE_LAST)) begin
          timeout_hit = 1'b1;
          close_txn   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_owner_q  <= LAST_RST;
      owner_q       <= '0;
      gap_cnt       <= '0;
      idle_cnt      <= '0;
      gpio_wen      <= 1'b0;
      gpio_wdata    <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      gpio_wen      <= xfer;
      timeout_pulse <= timeout_hit;
      if (xfer) begin
        owner_q    <= sel;
        gpio_wdata <= sel_word;
        gap_cnt    <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      if (close_txn) begin
        last_owner_q <= sel;
      end
      // Gap cycles count as idle time for the lock watchdog.
      if (xfer || (state_q == S_IDLE)) begin
        idle_cnt <= '0;
      end else if (TIMEOUT_CYCLES != 0) begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  assign locked = (state_q == S_LOCK);
  assign owner  = owner_q;
  assign busy   = locked | (gap_cnt != '0);

endmodule

// File: tb/tb_gpio_cmd_arbiter.sv
// tb/tb_gpio_cmd_arbiter.sv - randomized and directed checks of gpio_cmd_arbiter against a transaction-level model
module tb_gpio_cmd_arbiter;
  import gpio_cmd_pkg::*;

  localparam int NR  = 2;
  localparam int GAP = 1;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [32*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            gpio_wen;
  logic [31:0]     gpio_wdata;
  logic            locked;
  logic [0:0]      owner;
  logic            timeout_pulse;
  logic            busy;

  gpio_cmd_arbiter #(
    .NUM_REQ        (NR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .gpio_wen      (gpio_wen),
    .gpio_wdata    (gpio_wdata),
    .locked        (locked),
    .owner         (owner),
    .timeout_pulse (timeout_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  int          to_cnt = 0;
  logic [31:0] emitted[$];
  int          wen_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (gpio_wen) begin
      emitted.push_back(gpio_wdata);
      wen_cyc.push_back(cyc);
    end
    if (timeout_pulse) to_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] rq [NR][$];
  logic [31:0] exp_q[$];
  int          m_last;

  task automatic add_txn(input int r, input int len);
    for (int i = 0; i < len - 1; i++)
      rq[r].push_back({4'($urandom_range(0, 14)), 28'($urandom)});
    rq[r].push_back({4'hF, 28'($urandom)});
  endtask

  // Whole transactions, round-robin among requesters that still have work.
  task automatic build_expected();
    logic [31:0] mq [NR][$];
    logic [31:0] w;
    int r;
    bit found;
    exp_q.delete();
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    r = 0;
    for (int t = 0; t < 1000; t++) begin
      found = 1'b0;
      for (int k = 1; k <= NR && !found; k++) begin
        r = (m_last + k) % NR;
        if (mq[r].size() > 0) found = 1'b1;
      end
      if (!found) break;
      do begin
        w = mq[r].pop_front();
        exp_q.push_back(w);
      end while (!is_commit(w));
      m_last = r;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wen", gpio_wen, 0);
    check("rst_wdata", gpio_wdata, 0);
    check("rst_locked", locked, 0);
    check("rst_owner", owner, 0);
    check("rst_pulse", timeout_pulse, 0);
    check("rst_busy", busy, 0);
    rst_n  = 1'b1;
    m_last = NR - 1;
  endtask

  task automatic push(input int r, input logic [31:0] w);
    int n = 0;
    req_valid[r] = 1'b1;
    req_data[32*r +: 32] = w;
    #1;
    while (!req_ready[r] && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("push_wait", n < 200, 1);
    @(negedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic run_queues(input bit stalls, input bit exact);
    int stall[NR];
    logic [NR-1:0] acc;
    int onehot_bad = 0, gap_bad = 0, lock_bad = 0, left = 0, base;
    bit mid;
    #1;
    base = emitted.size();
    build_expected();
    for (int r = 0; r < NR; r++) stall[r] = 0;
    for (int n = 0; n < 5000; n++) begin
      left = 0;
      for (int r = 0; r < NR; r++) left += rq[r].size();
      if (left == 0) break;
      for (int r = 0; r < NR; r++) begin
        if (rq[r].size() > 0 && stall[r] == 0) begin
          req_valid[r] = 1'b1;
          req_data[32*r +: 32] = rq[r][0];
        end else begin
          req_valid[r] = 1'b0;
        end
      end
      #1;
      acc = req_valid & req_ready;
      if ($countones(req_ready) > 1) onehot_bad++;
      if (gpio_wen && req_ready != '0) gap_bad++;
      for (int r = 0; r < NR; r++)
        if (locked && req_ready[r] && r != int'(owner)) lock_bad++;
      for (int r = 0; r < NR; r++) begin
        if (acc[r]) begin
          mid = !is_commit(rq[r][0]);
          void'(rq[r].pop_front());
          if (stalls && mid && $urandom_range(0, 3) == 0) stall[r] = $urandom_range(1, 6);
        end else if (stall[r] > 0) begin
          stall[r]--;
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("run_drained", left, 0);
    repeat (4) @(negedge clk);
    #1;
    check("onehot_ready", onehot_bad, 0);
    check("ready_in_gap", gap_bad, 0);
    check("ready_nonowner", lock_bad, 0);
    check("emit_count", emitted.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < emitted.size(); i++)
      check($sformatf("word%0d", i), emitted[base+i], exp_q[i]);
    for (int i = base + 1; i < wen_cyc.size(); i++) begin
      if (exact) check("spacing", wen_cyc[i] - wen_cyc[i-1], GAP + 1);
      else       check("spacing_min", (wen_cyc[i] - wen_cyc[i-1]) >= GAP + 1, 1);
    end
  endtask

  initial begin
    int base, k, to0;
    do_reset();

    // Single requester, three words, fixed data.
    @(negedge clk);
    base = emitted.size();
    push(0, 32'h1000_0005);
    check("t1_lock_a", locked, 1);
    check("t1_owner", owner, 0);
    push(0, 32'h2000_0ABC);
    check("t1_lock_b", locked, 1);
    push(0, 32'hF000_0000);
    check("t1_lock_c", locked, 0);
    repeat (3) @(negedge clk);
    #1;
    check("t1_count", emitted.size() - base, 3);
    if (emitted.size() - base == 3) begin
      check("t1_w0", emitted[base], 32'h1000_0005);
      check("t1_w1", emitted[base+1], 32'h2000_0ABC);
      check("t1_w2", emitted[base+2], 32'hF000_0000);
      check("t1_gap0", wen_cyc[base+1] - wen_cyc[base], 2);
      check("t1_gap1", wen_cyc[base+2] - wen_cyc[base+1], 2);
    end

    // Lone COMMIT from req0 then req1 should be preferred.
    do_reset();
    @(negedge clk);
    push(0, 32'hF000_0000);
    check("t5_locked", locked, 0);
    check("t5_wen", gpio_wen, 1);
    m_last = 0;
    @(negedge clk);
    add_txn(0, 2);
    add_txn(1, 2);
    run_queues(1'b0, 1'b1);

    // Two contenders, then two transactions each for fairness.
    add_txn(0, 3);
    add_txn(1, 3);
    run_queues(1'b0, 1'b1);
    for (int t = 0; t < 2; t++) begin
      add_txn(0, 3);
      add_txn(1, 3);
    end
    run_queues(1'b0, 1'b1);

    // Timeout of a stalled owner.
    to0 = to_cnt;
    #1;
    base = emitted.size();
    push(1, 32'h1800_0003);
    req_valid[0] = 1'b1;
    req_data[31:0] = 32'hF000_0001;
    k = 1;
    while (!timeout_pulse && k < 100) begin
      @(negedge clk);
      #1;
      k++;
      if (k == 5) check("to_ready0_blocked", req_ready[0], 0);
    end
    check("to_latency", k, TMO + 1);
    check("to_locked", locked, 0);
    check("to_ready0", req_ready[0], 1);
    check("to_no_extra_wen", emitted.size() - base, 1);
    @(negedge clk);
    #1;
    req_valid[0] = 1'b0;
    check("to_pulse_width", timeout_pulse, 0);
    check("to_owner", owner, 0);
    check("to_grant_data", gpio_wdata, 32'hF000_0001);
    check("to_pulses", to_cnt - to0, 1);
    m_last = 0;
    repeat (2) @(negedge clk);

    // Randomized traffic with owner stalls below the timeout.
    to0 = to_cnt;
    for (int round = 0; round < 6; round++) begin
      for (int r = 0; r < NR; r++) begin
        int nt;
        nt = $urandom_range(0, 3);
        for (int t = 0; t < nt; t++) add_txn(r, $urandom_range(1, 4));
      end
      run_queues(1'b1, 1'b0);
    end
    check("rand_no_timeout", to_cnt - to0, 0);

    // Reset while req1 holds a lock.
    push(1, 32'h1800_0007);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_wen", gpio_wen, 0);
    check("mr_wdata", gpio_wdata, 0);
    check("mr_locked", locked, 0);
    check("mr_owner", owner, 0);
    check("mr_busy", busy, 0);
    check("mr_pulse", timeout_pulse, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = NR - 1;
    #1;
    base = emitted.size();
    repeat (3) @(negedge clk);
    #1;
    check("mr_no_strobe", emitted.size() - base, 0);
    add_txn(1, 2);
    add_txn(0, 2);
    run_queues(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
